// File: rtl/coo_aggr_if.sv
// ============================================================================
// Module : coo_aggr_if
// Brief  : Start/done handshake, COO read port and row-select bus of the
//          GCN aggregation sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface coo_aggr_if #(
  parameter int COO_IDX_WIDTH = 3,
  parameter int COO_BW        = 3,
  parameter int FEATURE_WIDTH = 3
);
  logic                               start;
  logic [1:0][COO_IDX_WIDTH-1:0]      coo_in;
  logic                               busy;
  logic                               done;
  logic [COO_BW-1:0]                  coo_address;
  logic                               enable_read_row_1;
  logic                               write_enable;
  logic                               acc_en;
  logic                               adj_clear;
  logic [FEATURE_WIDTH-1:0]           clear_row;

  modport master (
    input  start, coo_in,
    output busy, done, coo_address, enable_read_row_1, write_enable,
           acc_en, adj_clear, clear_row
  );

  modport slave (
    output start, coo_in,
    input  busy, done, coo_address, enable_read_row_1, write_enable,
           acc_en, adj_clear, clear_row
  );
endinterface

`default_nettype wire

// File: rtl/coo_aggr_ctrl.sv
// ============================================================================
// Module : coo_aggr_ctrl
// Brief  : Clears the adjacency result memory, then walks the COO edge list
//          issuing two-phase accumulate strobes per edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coo_aggr_ctrl #(
  parameter int FEATURE_ROWS    = 6,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_IDX_WIDTH   = 3,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int FEATURE_WIDTH   = $clog2(FEATURE_ROWS)
) (
  input  wire logic  clk,
  input  wire logic  reset,
  coo_aggr_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_EDGE_A = 3'd3,
    S_EDGE_B = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COO_BW-1:0]        LAST_COL = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [COO_IDX_WIDTH:0]   MAX_IDX  = (COO_IDX_WIDTH + 1)'(FEATURE_ROWS);

  state_t                   state_q, state_d;
  logic [COO_BW-1:0]        coo_address_q, coo_address_d;
  logic [FEATURE_WIDTH-1:0] clear_row_q, clear_row_d;

  logic idx0_ok, idx1_ok, edge_valid, self_loop, last_col, next_col;
  logic rd_row1, wr_en, acc;

  // COO indices are 1-based; 0 and anything past the last node mark padding.
  assign idx0_ok    = (bus.coo_in[0] != '0) && ({1'b0, bus.coo_in[0]} <= MAX_IDX);
  assign idx1_ok    = (bus.coo_in[1] != '0) && ({1'b0, bus.coo_in[1]} <= MAX_IDX);
  assign edge_valid = idx0_ok && idx1_ok;
  assign self_loop  = (bus.coo_in[0] == bus.coo_in[1]);
  assign last_col   = (coo_address_q == LAST_COL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      coo_address_q <= '0;
      clear_row_q   <= '0;
    end else begin
      state_q       <= state_d;
      coo_address_q <= coo_address_d;
      clear_row_q   <= clear_row_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    coo_address_d = coo_address_q;
    clear_row_d   = clear_row_q;
    rd_row1       = 1'b0;
    wr_en         = 1'b0;
    acc           = 1'b0;
    next_col      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_CLEAR;
          clear_row_d   = '0;
          coo_address_d = '0;
        end
      end
      S_CLEAR: begin
        if (clear_row_q == LAST_ROW) state_d = S_FETCH;
        else                         clear_row_d = clear_row_q + 1'b1;
      end
      S_FETCH: state_d = S_EDGE_A;
      S_EDGE_A: begin
        if (!edge_valid) begin
          next_col = 1'b1;
        end else begin
          rd_row1 = 1'b1;
          acc     = 1'b1;
          if (self_loop) next_col = 1'b1;
          else           state_d  = S_EDGE_B;
        end
      end
      S_EDGE_B: begin
        wr_en    = 1'b1;
        acc      = 1'b1;
        next_col = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Compare before increment so the last column never wraps the address.
    if (next_col) begin
      if (last_col) begin
        state_d = S_DONE;
      end else begin
        coo_address_d = coo_address_q + 1'b1;
        state_d       = S_FETCH;
      end
    end
  end

  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = (state_q == S_DONE);
  assign bus.adj_clear         = (state_q == S_CLEAR);
  assign bus.clear_row         = clear_row_q;
  assign bus.coo_address       = coo_address_q;
  assign bus.enable_read_row_1 = rd_row1;
  assign bus.write_enable      = wr_en;
  assign bus.acc_en            = acc;

endmodule

`default_nettype wire
